calc_core_sequencer: RTL and testbench



---
 rtl/calc_core_sequencer_if.sv | 51 +++++
 rtl/calc_core_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_calc_core_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/calc_core_sequencer_if.sv
// Host-side bundle of calc_core_sequencer: program writes, run control,
// operand loads, read requests/responses and status.
interface calc_core_sequencer_if #(
    parameter int WORD_SIZE      = 256,
    parameter int RAM_ADDR_SIZE  = 8,
    parameter int MODE_SIZE      = 4,
    parameter int PROG_ADDR_SIZE = 6,
    parameter int CMD_SIZE       = MODE_SIZE + 3 * RAM_ADDR_SIZE
);
    logic                      prog_we;
    logic [PROG_ADDR_SIZE-1:0] prog_waddr;
    logic [CMD_SIZE-1:0]       prog_wcmd;
    logic                      start;
    logic [PROG_ADDR_SIZE:0]   prog_len;

    logic                      load_valid;
    logic                      load_ready;
    logic [RAM_ADDR_SIZE-1:0]  load_addr1;
    logic [RAM_ADDR_SIZE-1:0]  load_addr2;
    logic [WORD_SIZE-1:0]      load_data1;
    logic [WORD_SIZE-1:0]      load_data2;

    logic                      rd_valid;
    logic                      rd_ready;
    logic [RAM_ADDR_SIZE-1:0]  rd_addr1;
    logic [RAM_ADDR_SIZE-1:0]  rd_addr2;
    logic                      rd_resp_valid;
    logic [WORD_SIZE-1:0]      rd_data1;
    logic [WORD_SIZE-1:0]      rd_data2;

    logic                      busy;
    logic                      done;
    logic                      error;
    logic [PROG_ADDR_SIZE-1:0] err_pc;

    modport master (
        output prog_we, prog_waddr, prog_wcmd, start, prog_len,
        output load_valid, load_addr1, load_addr2, load_data1, load_data2,
        output rd_valid, rd_addr1, rd_addr2,
        input  load_ready, rd_ready, rd_resp_valid, rd_data1, rd_data2,
        input  busy, done, error, err_pc
    );

    modport slave (
        input  prog_we, prog_waddr, prog_wcmd, start, prog_len,
        input  load_valid, load_addr1, load_addr2, load_data1, load_data2,
        input  rd_valid, rd_addr1, rd_addr2,
        output load_ready, rd_ready, rd_resp_valid, rd_data1, rd_data2,
        output busy, done, error, err_pc
    );
endinterface

// File: rtl/calc_core_sequencer.sv
// Command initiator for a CalculationCore: loads operands, runs a stored
// program of top_cmd words one at a time with a per-command timeout, reads back results.
module calc_core_sequencer #(
    parameter int WORD_SIZE      = 256,
    parameter int RAM_ADDR_SIZE  = 8,
    parameter int MODE_SIZE      = 4,
    parameter int PROG_ADDR_SIZE = 6,
    parameter int CMD_SIZE       = MODE_SIZE + 3 * RAM_ADDR_SIZE,
    parameter int TIMEOUT        = 4095
) (
    input  logic                     clk,
    input  logic                     rst_n,
    calc_core_sequencer_if.slave     host,
    output logic [1:0]               I_INPUTMODE,
    output logic [CMD_SIZE-1:0]      top_cmd,
    output logic [RAM_ADDR_SIZE-1:0] I_WADDR1,
    output logic [RAM_ADDR_SIZE-1:0] I_WADDR2,
    output logic [WORD_SIZE-1:0]     I_WDATA1,
    output logic [WORD_SIZE-1:0]     I_WDATA2,
    output logic [RAM_ADDR_SIZE-1:0] I_RADDR1,
    output logic [RAM_ADDR_SIZE-1:0] I_RADDR2,
    input  logic [WORD_SIZE-1:0]     outdata1,
    input  logic [WORD_SIZE-1:0]     outdata2,
    input  logic                     finished_flag
);
    localparam int TO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_FETCH, S_EXEC, S_GAP, S_READ, S_RESP, S_ERR
    } state_t;

    state_t state_reg, state_next;

    logic [CMD_SIZE-1:0]       prog_mem [2**PROG_ADDR_SIZE];
    logic [PROG_ADDR_SIZE:0]   pc_reg;
    logic [PROG_ADDR_SIZE:0]   len_reg;
    logic [TO_W-1:0]           cnt_reg;
    logic [CMD_SIZE-1:0]       cmd_reg;
    logic [RAM_ADDR_SIZE-1:0]  waddr1_reg, waddr2_reg, raddr1_reg, raddr2_reg;
    logic [WORD_SIZE-1:0]      wdata1_reg, wdata2_reg, rdata1_reg, rdata2_reg;
    logic                      done_reg;
    logic                      error_reg;
    logic [PROG_ADDR_SIZE-1:0] err_pc_reg;

    logic                      idle, start_acc, load_acc, rd_acc, last_cmd, timed_out;
    logic [PROG_ADDR_SIZE:0]   pc_inc;

    assign idle      = (state_reg == S_IDLE);
    assign start_acc = idle && host.start;
    assign load_acc  = idle && !host.start && host.load_valid;
    assign rd_acc    = idle && !host.start && !host.load_valid && host.rd_valid;
    assign pc_inc    = pc_reg + 1'b1;
    assign last_cmd  = (pc_inc == len_reg);
    // Compared one early: this is the TIMEOUT-th EXEC cycle of the command.
    assign timed_out = (cnt_reg == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (host.start) begin
                    state_next = (host.prog_len == '0) ? S_IDLE : S_FETCH;
                end else if (host.load_valid) begin
                    state_next = S_LOAD;
                end else if (host.rd_valid) begin
                    state_next = S_READ;
                end
            end
            S_LOAD:  state_next = S_IDLE;
            S_FETCH: state_next = S_EXEC;
            S_EXEC: begin
                if (finished_flag) begin
                    state_next = S_GAP;
                end else if (timed_out) begin
                    state_next = S_ERR;
                end
            end
            S_GAP:   state_next = last_cmd ? S_IDLE : S_FETCH;
            S_READ:  state_next = S_RESP;
            S_RESP:  state_next = S_IDLE;
            S_ERR:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        I_INPUTMODE        = 2'd0;
        host.load_ready    = 1'b0;
        host.rd_ready      = 1'b0;
        host.rd_resp_valid = 1'b0;
        host.busy          = !idle;
        case (state_reg)
            S_IDLE: begin
                host.load_ready = !host.start;
                // Load outranks read, so a read is only acknowledged when no load is pending.
                host.rd_ready   = !host.start && !host.load_valid;
            end
            S_LOAD:  I_INPUTMODE = 2'd1;
            S_EXEC:  I_INPUTMODE = 2'd2;
            S_READ:  I_INPUTMODE = 2'd3;
            S_RESP:  host.rd_resp_valid = 1'b1;
            default: I_INPUTMODE = 2'd0;
        endcase
    end

    // Program store survives reset.
    always_ff @(posedge clk) begin
        if (host.prog_we && idle) begin
            prog_mem[host.prog_waddr] <= host.prog_wcmd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg     <= '0;
            len_reg    <= '0;
            cnt_reg    <= '0;
            cmd_reg    <= '0;
            waddr1_reg <= '0;
            waddr2_reg <= '0;
            wdata1_reg <= '0;
            wdata2_reg <= '0;
            raddr1_reg <= '0;
            raddr2_reg <= '0;
            rdata1_reg <= '0;
            rdata2_reg <= '0;
            done_reg   <= 1'b0;
            error_reg  <= 1'b0;
            err_pc_reg <= '0;
        end else begin
            done_reg <= (start_acc && host.prog_len == '0) || (state_reg == S_GAP && last_cmd);
            if (start_acc) begin
                pc_reg    <= '0;
                len_reg   <= host.prog_len;
                error_reg <= 1'b0;
            end
            if (state_reg == S_FETCH) begin
                cmd_reg <= prog_mem[pc_reg[PROG_ADDR_SIZE-1:0]];
                cnt_reg <= '0;
            end
            if (state_reg == S_EXEC) begin
                cnt_reg <= cnt_reg + 1'b1;
                if (!finished_flag && timed_out) begin
                    error_reg  <= 1'b1;
                    err_pc_reg <= pc_reg[PROG_ADDR_SIZE-1:0];
                end
            end
            if (state_reg == S_GAP) begin
                pc_reg <= pc_inc;
            end
            if (load_acc) begin
                waddr1_reg <= host.load_addr1;
                waddr2_reg <= host.load_addr2;
                wdata1_reg <= host.load_data1;
                wdata2_reg <= host.load_data2;
            end
            if (rd_acc) begin
                raddr1_reg <= host.rd_addr1;
                raddr2_reg <= host.rd_addr2;
            end
            if (state_reg == S_READ) begin
                rdata1_reg <= outdata1;
                rdata2_reg <= outdata2;
            end
        end
    end

    assign top_cmd       = cmd_reg;
    assign I_WADDR1      = waddr1_reg;
    assign I_WADDR2      = waddr2_reg;
    assign I_WDATA1      = wdata1_reg;
    assign I_WDATA2      = wdata2_reg;
    assign I_RADDR1      = raddr1_reg;
    assign I_RADDR2      = raddr2_reg;
    assign host.rd_data1 = rdata1_reg;
    assign host.rd_data2 = rdata2_reg;
    assign host.done     = done_reg;
    assign host.error    = error_reg;
    assign host.err_pc   = err_pc_reg;
endmodule

// File: tb/tb_calc_core_sequencer.sv
// Randomized bench for calc_core_sequencer with a behavioural core stand-in
// and a schedule model computed from command durations.
module tb_calc_core_sequencer;
    localparam int WS = 256;
    localparam int RA = 8;
    localparam int MS = 4;
    localparam int PA = 6;
    localparam int CS = MS + 3 * RA;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    calc_core_sequencer_if #(.WORD_SIZE(WS), .RAM_ADDR_SIZE(RA), .MODE_SIZE(MS),
                             .PROG_ADDR_SIZE(PA)) host ();

    logic [1:0]    I_INPUTMODE;
    logic [CS-1:0] top_cmd;
    logic [RA-1:0] I_WADDR1, I_WADDR2, I_RADDR1, I_RADDR2;
    logic [WS-1:0] I_WDATA1, I_WDATA2, outdata1, outdata2;
    logic          finished_flag;

    calc_core_sequencer #(.WORD_SIZE(WS), .RAM_ADDR_SIZE(RA), .MODE_SIZE(MS),
                          .PROG_ADDR_SIZE(PA), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .host(host),
        .I_INPUTMODE(I_INPUTMODE), .top_cmd(top_cmd),
        .I_WADDR1(I_WADDR1), .I_WADDR2(I_WADDR2),
        .I_WDATA1(I_WDATA1), .I_WDATA2(I_WDATA2),
        .I_RADDR1(I_RADDR1), .I_RADDR2(I_RADDR2),
        .outdata1(outdata1), .outdata2(outdata2),
        .finished_flag(finished_flag)
    );

    // Core stand-in: dual write (port 2 last), combinational read, and a
    // finished_flag raised in the ntab[i]-th EXEC cycle of command i (0 = never).
    logic [WS-1:0] cram [256];
    int ntab [65];
    int ecnt = 0;
    int cmd_idx = 0;

    always @(posedge clk) begin
        if (I_INPUTMODE == 2'd1) begin
            cram[I_WADDR1] <= I_WDATA1;
            cram[I_WADDR2] <= I_WDATA2;
        end
        if (I_INPUTMODE == 2'd2) ecnt <= ecnt + 1;
        else                     ecnt <= 0;
        if (!host.busy)          cmd_idx <= 0;
        else if (finished_flag)  cmd_idx <= cmd_idx + 1;
    end
    assign finished_flag = (I_INPUTMODE == 2'd2) && (ntab[cmd_idx] != 0) && (ecnt + 1 == ntab[cmd_idx]);
    assign outdata1 = cram[I_RADDR1];
    assign outdata2 = cram[I_RADDR2];

    logic [WS-1:0] ref_mem [256];
    bit            loaded [256];
    logic [CS-1:0] cmds [64];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [WS-1:0] got, input logic [WS-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WS-1:0] rnd_word();
        logic [WS-1:0] w;
        for (int i = 0; i < WS / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic do_load(input logic [RA-1:0] a1, input logic [RA-1:0] a2,
                           input logic [WS-1:0] d1, input logic [WS-1:0] d2);
        host.load_valid = 1'b1;
        host.load_addr1 = a1;
        host.load_addr2 = a2;
        host.load_data1 = d1;
        host.load_data2 = d2;
        #1;
        for (int n = 0; n < 50 && !host.load_ready; n++) tick();
        check("load_ready", WS'(host.load_ready), WS'(1));
        tick();
        host.load_valid = 1'b0;
        check("load_mode", WS'(I_INPUTMODE), WS'(1));
        check("load_waddr", WS'({I_WADDR1, I_WADDR2}), WS'({a1, a2}));
        check("load_wdata1", I_WDATA1, d1);
        check("load_wdata2", I_WDATA2, d2);
        ref_mem[a1] = d1;
        ref_mem[a2] = d2;
        loaded[a1] = 1'b1;
        loaded[a2] = 1'b1;
        tick();
        check("load_end_mode", WS'(I_INPUTMODE), WS'(0));
    endtask

    task automatic do_read(input logic [RA-1:0] a1, input logic [RA-1:0] a2);
        host.rd_valid = 1'b1;
        host.rd_addr1 = a1;
        host.rd_addr2 = a2;
        #1;
        for (int n = 0; n < 50 && !host.rd_ready; n++) tick();
        check("rd_ready", WS'(host.rd_ready), WS'(1));
        tick();
        host.rd_valid = 1'b0;
        check("read_mode", WS'(I_INPUTMODE), WS'(3));
        check("read_raddr", WS'({I_RADDR1, I_RADDR2}), WS'({a1, a2}));
        tick();
        check("resp_valid", WS'(host.rd_resp_valid), WS'(1));
        check("resp_data1", host.rd_data1, ref_mem[a1]);
        check("resp_data2", host.rd_data2, ref_mem[a2]);
        tick();
        check("resp_pulse", WS'(host.rd_resp_valid), WS'(0));
    endtask

    // Runs cmds[0..len-1] with EXEC durations ntab[]; expected timing is
    // derived from FETCH 1 + EXEC N + GAP 1 per command, 1 cycle after start.
    task automatic run_prog(input int len, input bit write_prog, input bit collide, input bit junk_we);
        int exp_done_t, exp_err_t, exp_err_pc, exp_runs, acc;
        int run_idx, run_len, gap, elen;
        bit in_run, stable, done_seen, err_seen, stall_ok;
        logic [CS-1:0] first_cmd;
        logic [RA-1:0] ca1, ca2;
        logic [WS-1:0] cd1, cd2;

        acc = 1; exp_done_t = -1; exp_err_t = -1; exp_err_pc = -1; exp_runs = 0;
        for (int i = 0; i < len; i++) begin
            exp_runs++;
            if (ntab[i] == 0 || ntab[i] > TO) begin
                exp_err_t = acc + 1 + TO;
                exp_err_pc = i;
                break;
            end
            acc += ntab[i] + 2;
        end
        if (exp_err_pc < 0) exp_done_t = acc;

        if (write_prog) begin
            for (int i = 0; i < len; i++) begin
                host.prog_we = 1'b1;
                host.prog_waddr = PA'(i);
                host.prog_wcmd = cmds[i];
                tick();
            end
            host.prog_we = 1'b0;
        end

        ca1 = RA'($urandom_range(0, 15)); ca2 = RA'($urandom_range(0, 15));
        cd1 = rnd_word(); cd2 = rnd_word();
        host.start = 1'b1;
        host.prog_len = 7'(len);
        if (collide) begin
            host.load_valid = 1'b1;
            host.load_addr1 = ca1; host.load_addr2 = ca2;
            host.load_data1 = cd1; host.load_data2 = cd2;
        end
        #1;
        check("start_load_ready", WS'(host.load_ready), WS'(0));
        tick();
        host.start = 1'b0;

        run_idx = 0; run_len = 0; gap = 0; in_run = 0; stable = 1;
        done_seen = 0; err_seen = 0; stall_ok = 1; first_cmd = '0;
        for (int t = 1; t <= 2000; t++) begin
            if (t == 1) check("err_clear", WS'(host.error), WS'(0));
            if (I_INPUTMODE == 2'd2) begin
                if (!in_run) begin
                    if (run_idx > 0) check("gap_len", WS'(gap), WS'(2));
                    check("top_cmd", WS'(top_cmd), WS'(cmds[run_idx]));
                    in_run = 1; run_len = 0; stable = 1; first_cmd = top_cmd;
                end
                if (top_cmd !== first_cmd) stable = 0;
                run_len++;
            end else if (in_run) begin
                elen = (ntab[run_idx] == 0 || ntab[run_idx] > TO) ? TO : ntab[run_idx];
                check("exec_len", WS'(run_len), WS'(elen));
                check("cmd_stable", WS'(stable), WS'(1));
                in_run = 0; gap = 0; run_idx++;
            end
            if (I_INPUTMODE != 2'd2 && host.busy) gap++;
            if (collide && host.busy && host.load_ready) stall_ok = 0;
            if (junk_we) begin
                host.prog_we = host.busy;
                host.prog_waddr = '0;
                host.prog_wcmd = ~cmds[0];
            end
            if (host.done) begin
                check("done_t", WS'(t), WS'(exp_done_t));
                check("busy_at_done", WS'(host.busy), WS'(0));
                done_seen = 1;
                break;
            end
            if (host.error && !err_seen) begin
                check("err_t", WS'(t), WS'(exp_err_t));
                check("err_pc", WS'(host.err_pc), WS'(exp_err_pc));
                err_seen = 1;
            end
            if (err_seen && !host.busy) begin
                check("err_sticky", WS'(host.error), WS'(1));
                break;
            end
            tick();
        end
        host.prog_we = 1'b0;
        check("run_finished", WS'(done_seen | err_seen), WS'(1));
        check("run_count", WS'(run_idx), WS'(exp_runs));

        if (collide) begin
            check("load_stalled", WS'(stall_ok), WS'(1));
            check("load_ready_after", WS'(host.load_ready), WS'(1));
            tick();
            host.load_valid = 1'b0;
            check("done_pulse", WS'(host.done), WS'(0));
            check("col_mode", WS'(I_INPUTMODE), WS'(1));
            check("col_wdata2", I_WDATA2, cd2);
            ref_mem[ca1] = cd1; ref_mem[ca2] = cd2;
            loaded[ca1] = 1'b1; loaded[ca2] = 1'b1;
            tick();
        end else begin
            tick();
            check("done_pulse", WS'(host.done), WS'(0));
        end
    endtask

    task automatic rand_cmds(input int len);
        for (int i = 0; i < len; i++) cmds[i] = CS'($urandom);
    endtask

    initial begin
        int len;
        bit junk;
        logic [RA-1:0] a1, a2;

        host.prog_we = 0; host.prog_waddr = '0; host.prog_wcmd = '0;
        host.start = 0; host.prog_len = '0;
        host.load_valid = 0; host.load_addr1 = '0; host.load_addr2 = '0;
        host.load_data1 = '0; host.load_data2 = '0;
        host.rd_valid = 0; host.rd_addr1 = '0; host.rd_addr2 = '0;
        for (int i = 0; i < 65; i++) ntab[i] = 0;

        repeat (3) tick();
        check("rst_mode", WS'(I_INPUTMODE), WS'(0));
        check("rst_load_ready", WS'(host.load_ready), WS'(1));
        check("rst_rd_ready", WS'(host.rd_ready), WS'(1));
        check("rst_busy", WS'(host.busy), WS'(0));
        check("rst_done", WS'(host.done), WS'(0));
        check("rst_error", WS'(host.error), WS'(0));
        check("rst_resp_valid", WS'(host.rd_resp_valid), WS'(0));
        check("rst_top_cmd", WS'(top_cmd), WS'(0));
        check("rst_err_pc", WS'(host.err_pc), WS'(0));
        check("rst_rd_data1", host.rd_data1, WS'(0));
        rst_n = 1'b1;
        tick();

        do_load(8'd3, 8'd4, WS'(32'hA), WS'(32'hB));
        do_read(8'd3, 8'd4);
        do_load(8'd5, 8'd5, rnd_word(), rnd_word());
        do_read(8'd5, 8'd3);

        for (int i = 0; i < 8; i++)
            do_load(RA'($urandom_range(0, 15)), RA'($urandom_range(0, 15)), rnd_word(), rnd_word());
        for (int i = 0; i < 6; i++) begin
            do begin a1 = RA'($urandom_range(0, 15)); end while (!loaded[a1]);
            do begin a2 = RA'($urandom_range(0, 15)); end while (!loaded[a2]);
            do_read(a1, a2);
        end

        rand_cmds(2); ntab[0] = 5; ntab[1] = 7;
        run_prog(2, 1, 0, 0);

        run_prog(0, 1, 0, 0);

        rand_cmds(2); ntab[0] = 0; ntab[1] = 3;
        run_prog(2, 1, 0, 0);
        ntab[0] = 3;
        run_prog(1, 1, 0, 0);

        rand_cmds(2); ntab[0] = TO; ntab[1] = 1;
        run_prog(2, 1, 0, 0);

        for (int r = 0; r < 6; r++) begin
            len = $urandom_range(1, 6);
            junk = 1'($urandom_range(0, 1));
            rand_cmds(len);
            for (int i = 0; i < len; i++) ntab[i] = $urandom_range(1, TO + 2);
            run_prog(len, 1, 0, junk);
            if (junk) run_prog(len, 0, 0, 0);
        end

        rand_cmds(64);
        for (int i = 0; i < 64; i++) ntab[i] = 1;
        run_prog(64, 1, 0, 0);

        rand_cmds(1); ntab[0] = 3;
        run_prog(1, 1, 1, 0);
        do_read(host.load_addr1, host.load_addr2);

        rand_cmds(1); ntab[0] = 10;
        for (int i = 0; i < 1; i++) begin
            host.prog_we = 1'b1; host.prog_waddr = '0; host.prog_wcmd = cmds[0];
            tick();
        end
        host.prog_we = 1'b0;
        host.start = 1'b1; host.prog_len = 7'd1;
        tick();
        host.start = 1'b0;
        for (int n = 0; n < 50 && I_INPUTMODE != 2'd2; n++) tick();
        check("arst_in_exec", WS'(I_INPUTMODE), WS'(2));
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_mode", WS'(I_INPUTMODE), WS'(0));
        check("arst_busy", WS'(host.busy), WS'(0));
        check("arst_top_cmd", WS'(top_cmd), WS'(0));
        tick();
        rst_n = 1'b1;
        tick();
        ntab[0] = 4;
        run_prog(1, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
